// File: rtl/vc_trace_char_serializer.sv
// vc_trace_char_serializer
// Takes one right-justified packed character string per val/rdy transaction and
// replays it as a byte stream, first character first, optionally followed by a
// newline. All outputs are decoded from registered state only.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// val && rdy are both high; val never depends combinationally on rdy, and a
// producer holding val keeps its payload stable until the transfer.
module vc_trace_char_serializer #(
    parameter int p_nchars      = 16,
    parameter int p_len_nbits   = 5,
    parameter int p_add_newline = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [p_nchars*8-1:0]    in_msg,
    input  logic [p_len_nbits-1:0]   in_len,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [7:0]               out_msg,
    output logic                     out_eol
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        NL   = 2'd2
    } state_t;

    localparam logic [p_len_nbits-1:0] c_max_len = p_len_nbits'(p_nchars);
    localparam logic [p_len_nbits-1:0] c_one     = p_len_nbits'(1);
    localparam bit                     c_nl      = (p_add_newline != 0);

    state_t                 state;
    state_t                 state_next;
    logic [p_len_nbits-1:0] idx;
    logic [p_len_nbits-1:0] idx_next;
    logic [p_len_nbits-1:0] len_clamp;
    logic                   accept;
    logic [7:0]             chars [p_nchars];
    logic [7:0]             sel_byte;

    // Oversized lengths are limited to the buffer capacity at acceptance time.
    assign len_clamp = (in_len > c_max_len) ? c_max_len : in_len;
    assign accept    = (state == IDLE) && in_val;

    // Next-state and index update; idx counts down from the first character.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (in_val) begin
                    if (len_clamp != '0) begin
                        state_next = SEND;
                        idx_next   = len_clamp - c_one;
                    end else if (c_nl) begin
                        state_next = NL;
                    end
                end
            end
            SEND: begin
                if (out_rdy) begin
                    // Zero test comes first so idx never wraps below 0.
                    if (idx == '0) begin
                        state_next = c_nl ? NL : IDLE;
                    end else begin
                        idx_next = idx - c_one;
                    end
                end
            end
            NL: begin
                if (out_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and index registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Capture the whole string as bytes; byte i holds in_msg[i*8 +: 8].
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < p_nchars; i++) begin
                chars[i] <= in_msg[i*8 +: 8];
            end
        end
    end

    // Select the byte addressed by idx.
    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < p_nchars; i++) begin
            if (idx == p_len_nbits'(i)) begin
                sel_byte = chars[i];
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        in_rdy  = 1'b0;
        out_val = 1'b0;
        out_msg = 8'h00;
        out_eol = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
            end
            SEND: begin
                out_val = 1'b1;
                out_msg = sel_byte;
                out_eol = (idx == '0) && !c_nl;
            end
            NL: begin
                out_val = 1'b1;
                out_msg = 8'h0A;
                out_eol = 1'b1;
            end
            default: begin
                in_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vc_trace_char_serializer.sv
// Bench for vc_trace_char_serializer: one instance with newline termination and
// one without, each checked every cycle against a queue-of-bytes model.
module tb_vc_trace_char_serializer;

    typedef logic [7:0] bq_t [$];

    logic         clk = 1'b0;
    logic         reset;
    logic         in_val  [2];
    logic         in_rdy  [2];
    logic [127:0] in_msg  [2];
    logic [4:0]   in_len  [2];
    logic         out_val [2];
    logic         out_rdy [2];
    logic [7:0]   out_msg [2];
    logic         out_eol [2];
    bit           rdy_rand [2];
    bit           started = 1'b0;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    bit           pat [6];

    // clock / cycle counter / watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vc_trace_char_serializer #(.p_nchars(16), .p_len_nbits(5), .p_add_newline(1)) dut_nl (
        .clk(clk), .reset(reset),
        .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_msg(in_msg[0]), .in_len(in_len[0]),
        .out_val(out_val[0]), .out_rdy(out_rdy[0]), .out_msg(out_msg[0]), .out_eol(out_eol[0])
    );

    vc_trace_char_serializer #(.p_nchars(16), .p_len_nbits(5), .p_add_newline(0)) dut_raw (
        .clk(clk), .reset(reset),
        .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_msg(in_msg[1]), .in_len(in_len[1]),
        .out_val(out_val[1]), .out_rdy(out_rdy[1]), .out_msg(out_msg[1]), .out_eol(out_eol[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: the bytes still owed by the serializer, in emission order.
    // Empty queue means idle (ready for a string); head is the byte on the wire.
    for (genvar g = 0; g < 2; g++) begin : mdl
        logic [7:0] exp_q [$];
        logic [7:0] log_q [$];
        logic       prev_stall = 1'b0;
        logic [7:0] prev_msg = 8'h00;
        int         n;
        logic [127:0] m;

        always @(posedge clk) begin
            if (reset) begin
                exp_q.delete();
            end else if (exp_q.size() == 0) begin
                if (in_val[g]) begin
                    n = (int'(in_len[g]) > 16) ? 16 : int'(in_len[g]);
                    m = in_msg[g];
                    for (int k = 0; k < n; k++) exp_q.push_back(8'(m >> ((n - 1 - k) * 8)));
                    if (g == 0) exp_q.push_back(8'h0A);
                end
            end else if (out_rdy[g]) begin
                void'(exp_q.pop_front());
            end
        end

        always @(negedge clk) begin
            if (started) begin
                chk($sformatf("d%0d_in_rdy", g), in_rdy[g], exp_q.size() == 0);
                chk($sformatf("d%0d_out_val", g), out_val[g], exp_q.size() != 0);
                chk($sformatf("d%0d_out_eol", g), out_eol[g], exp_q.size() == 1);
                chk($sformatf("d%0d_out_msg", g), out_msg[g],
                    (exp_q.size() != 0) ? exp_q[0] : 8'h00);
                if (prev_stall) chk($sformatf("d%0d_stall_hold", g), out_msg[g], prev_msg);
                prev_stall = out_val[g] && !out_rdy[g] && !reset;
                prev_msg   = out_msg[g];
                if (out_val[g] && out_rdy[g] && !reset) log_q.push_back(out_msg[g]);
            end
        end
    end

    function automatic int qsize(input int d);
        if (d == 0) return mdl[0].exp_q.size();
        return mdl[1].exp_q.size();
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        mdl[0].log_q.delete();
        mdl[1].log_q.delete();
    endtask

    // driver: present a string and return just after the accepting edge
    task automatic send_str(input int d, input logic [127:0] m, input logic [4:0] l, input bit hold);
        int n = 0;
        bit ok = 1'b0;
        in_val[d] = 1'b1;
        in_msg[d] = m;
        in_len[d] = l;
        while (!ok && n < 400) begin
            @(negedge clk);
            if (in_rdy[d]) ok = 1'b1;
            else n++;
        end
        chk($sformatf("d%0d_accept", d), ok, 1'b1);
        step();
        if (!hold) in_val[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while (qsize(d) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("d%0d_idle_reached", d), qsize(d), 0);
        step();
    endtask

    task automatic check_log(input int d, input bq_t e, input string nm);
        bq_t got;
        if (d == 0) got = mdl[0].log_q;
        else got = mdl[1].log_q;
        chk({nm, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s_b%0d", nm, i), got[i], e[i]);
        end
    endtask

    task automatic rand_loop(input int d);
        logic [127:0] m;
        logic [4:0]   l;
        bit           hold;
        for (int i = 0; i < 120; i++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            l = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            hold = ($urandom_range(0, 2) == 0);
            send_str(d, m, l, hold);
            if (!hold) repeat ($urandom_range(0, 2)) step();
        end
        in_val[d] = 1'b0;
    endtask

    // random backpressure
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            if (rdy_rand[d]) out_rdy[d] = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        bq_t e;
        logic [127:0] m;
        int n;
        int c0;
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // reset held 3 cycles with a string offered
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_val[d] = 1'b1; in_msg[d] = 128'h616263; in_len[d] = 5'd3;
            out_rdy[d] = 1'b1; rdy_rand[d] = 1'b0;
        end
        step();
        started = 1'b1;
        step();
        step();
        reset = 1'b0;
        in_val[0] = 1'b0;
        in_val[1] = 1'b0;
        @(negedge clk);
        chk("reset_in_rdy", in_rdy[0], 1'b1);
        chk("reset_out_val", out_val[0], 1'b0);
        chk("reset_out_msg", out_msg[0], 8'h00);
        step();
        chk("reset_no_accept", mdl[0].log_q.size(), 0);

        // basic "abc"
        clear_logs();
        send_str(0, 128'h616263, 5'd3, 1'b0);
        wait_idle(0);
        e = '{8'h61, 8'h62, 8'h63, 8'h0A};
        check_log(0, e, "basic");
        chk("basic_rdy_after", in_rdy[0], 1'b1);

        // backpressure "hi"
        clear_logs();
        out_rdy[0] = 1'b0;
        send_str(0, 128'h6869, 5'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            out_rdy[0] = pat[i];
            step();
        end
        out_rdy[0] = 1'b1;
        wait_idle(0);
        e = '{8'h68, 8'h69, 8'h0A};
        check_log(0, e, "bp");

        // empty strings, no-newline variant
        clear_logs();
        send_str(0, 128'h0, 5'd0, 1'b0);
        wait_idle(0);
        e = '{8'h0A};
        check_log(0, e, "empty_nl");
        send_str(1, 128'h0, 5'd0, 1'b0);
        repeat (3) step();
        chk("empty_raw_len", mdl[1].log_q.size(), 0);
        send_str(1, 128'h616263, 5'd3, 1'b0);
        wait_idle(1);
        e = '{8'h61, 8'h62, 8'h63};
        check_log(1, e, "raw_abc");

        // full length and clamped length
        rdy_rand[0] = 1'b1;
        m = {$urandom, $urandom, $urandom, $urandom};
        clear_logs();
        send_str(0, m, 5'd16, 1'b0);
        wait_idle(0);
        chk("len16_count", mdl[0].log_q.size(), 17);
        chk("len16_first", mdl[0].log_q[0], m[127:120]);
        chk("len16_last", mdl[0].log_q[15], m[7:0]);
        chk("len16_nl", mdl[0].log_q[16], 8'h0A);
        m = {$urandom, $urandom, $urandom, $urandom};
        clear_logs();
        send_str(0, m, 5'd31, 1'b0);
        send_str(1, m, 5'd31, 1'b0);
        wait_idle(0);
        wait_idle(1);
        chk("len31_count", mdl[0].log_q.size(), 17);
        chk("len31_first", mdl[0].log_q[0], m[127:120]);
        chk("len31_raw_count", mdl[1].log_q.size(), 16);
        rdy_rand[0] = 1'b0;
        out_rdy[0] = 1'b1;

        // reset mid-string
        clear_logs();
        send_str(0, 128'h616263646566, 5'd6, 1'b0);
        n = 0;
        while (mdl[0].log_q.size() < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_val", out_val[0], 1'b0);
        chk("midrst_in_rdy", in_rdy[0], 1'b1);
        step();
        e = '{8'h61, 8'h62};
        check_log(0, e, "midrst");
        send_str(0, 128'h7A, 5'd1, 1'b0);
        wait_idle(0);
        e = '{8'h61, 8'h62, 8'h7A, 8'h0A};
        check_log(0, e, "after_rst");

        // back-to-back with in_val held
        clear_logs();
        send_str(0, 128'h616263, 5'd3, 1'b1);
        c0 = cyc;
        send_str(0, 128'h646566, 5'd3, 1'b0);
        n = 0;
        while (qsize(0) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_cycles", cyc - c0, 9);
        step();
        e = '{8'h61, 8'h62, 8'h63, 8'h0A, 8'h64, 8'h65, 8'h66, 8'h0A};
        check_log(0, e, "b2b");

        // randomized traffic on both instances
        rdy_rand[0] = 1'b1;
        rdy_rand[1] = 1'b1;
        fork
            rand_loop(0);
            rand_loop(1);
        join
        wait_idle(0);
        wait_idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
